hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the fetch/decode/execute datapath. Tracks pending register

---
 rtl/hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Decode-side hazard controller: register scoreboard, in-flight writer cap and redirect flush window.
// Optional macro HAZARD_ERR_EN adds a sticky err output that flags retires with no matching writer.
module hazard_ctrl #(
  parameter int NREG         = 16,
  parameter int REG_AW       = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs,
  input  logic              dec_rs_used,
  input  logic [REG_AW-1:0] dec_rq,
  input  logic              dec_rq_used,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_rd_wr,
  input  logic              ex_redirect,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              stall,
  output logic              issue,
  output logic              flush_dec,
  output logic              flush_ex,
  output logic [NREG-1:0]   busy_mask,
`ifdef HAZARD_ERR_EN
  output logic [3:0]        inflight,
  output logic              err
`else
  output logic [3:0]        inflight
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // cnt holds the number of FLUSH cycles still to follow the current one.
  localparam int CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);
  localparam logic [3:0] INFLIGHT_MAX = 4'(MAX_INFLIGHT);

  state_t          state_r, state_n;
  logic [CW-1:0]   cnt_r, cnt_n;
  logic [NREG-1:0] busy_r, busy_n;
  logic [3:0]      inflight_r, inflight_n;

  logic [NREG-1:0] wb_mask_s;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] eb_s;
  logic            haz_s;
  logic            inc_s;
  logic            dec_s;

  function automatic logic [NREG-1:0] onehot(input logic [REG_AW-1:0] idx, input logic en);
    logic [NREG-1:0] v;
    v = '0;
    if (en) begin
      v[idx] = 1'b1;
    end else begin
      v = '0;
    end
    return v;
  endfunction

  // Hazard detection against the effective scoreboard (same-cycle writeback already cleared).
  always_comb begin
    wb_mask_s = onehot(wb_rd, wb_valid);
    eb_s      = busy_r & ~wb_mask_s;
    haz_s     = (dec_rs_used & eb_s[dec_rs])
              | (dec_rq_used & eb_s[dec_rq])
              | (dec_rd_wr   & eb_s[dec_rd])
              | (dec_rd_wr & (inflight_r == INFLIGHT_MAX) & ~wb_valid);
  end

  // Sequencing FSM: redirect outranks stall/issue; all controls held low during reset.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    stall     = 1'b0;
    issue     = 1'b0;
    flush_dec = 1'b0;
    flush_ex  = 1'b0;
    if (!rst) begin
      case (state_r)
        ST_IDLE: begin
          if (ex_redirect) begin
            flush_ex  = 1'b1;
            flush_dec = 1'b1;
            cnt_n     = CNT_LOAD;
            state_n   = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
          end else begin
            issue = dec_valid & ~haz_s;
            stall = dec_valid & haz_s;
          end
        end
        ST_FLUSH: begin
          flush_dec = 1'b1;
          if (ex_redirect) begin
            flush_ex = 1'b1;
            cnt_n    = CNT_LOAD;
          end else if (cnt_r == '0) begin
            state_n = ST_IDLE;
          end else begin
            cnt_n = cnt_r - CW'(1);
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end else begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end
  end

  // Scoreboard and in-flight counter next state; a new writer wins over a same-cycle retire.
  always_comb begin
    inc_s      = issue & dec_rd_wr;
    dec_s      = wb_valid & (inflight_r != 4'd0);
    set_mask_s = onehot(dec_rd, inc_s);
    busy_n     = (busy_r & ~wb_mask_s) | set_mask_s;
    case ({inc_s, dec_s})
      2'b10:   inflight_n = inflight_r + 4'd1;
      2'b01:   inflight_n = inflight_r - 4'd1;
      default: inflight_n = inflight_r;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      busy_r     <= '0;
      inflight_r <= 4'd0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      busy_r     <= busy_n;
      inflight_r <= inflight_n;
    end
  end

  assign busy_mask = busy_r;
  assign inflight  = inflight_r;

`ifdef HAZARD_ERR_EN
  logic err_r;

  // Sticky flag for a retire that matches no outstanding writer.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (wb_valid & (~busy_r[wb_rd] | (inflight_r == 4'd0))) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (default parameters, FLUSH_CYCLES=2, MAX_INFLIGHT=4).
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        dec_valid;
  logic [3:0]  dec_rs;
  logic        dec_rs_used;
  logic [3:0]  dec_rq;
  logic        dec_rq_used;
  logic [3:0]  dec_rd;
  logic        dec_rd_wr;
  logic        ex_redirect;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic        stall;
  logic        issue;
  logic        flush_dec;
  logic        flush_ex;
  logic [15:0] busy_mask;
  logic [3:0]  inflight;
`ifdef HAZARD_ERR_EN
  logic        err;
`endif

  int checks;
  int failures;

  hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .dec_valid   (dec_valid),
    .dec_rs      (dec_rs),
    .dec_rs_used (dec_rs_used),
    .dec_rq      (dec_rq),
    .dec_rq_used (dec_rq_used),
    .dec_rd      (dec_rd),
    .dec_rd_wr   (dec_rd_wr),
    .ex_redirect (ex_redirect),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .stall       (stall),
    .issue       (issue),
    .flush_dec   (flush_dec),
    .flush_ex    (flush_ex),
    .busy_mask   (busy_mask),
`ifdef HAZARD_ERR_EN
    .inflight    (inflight),
    .err         (err)
`else
    .inflight    (inflight)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    dec_valid   = 1'b0;
    dec_rs      = 4'd0;
    dec_rs_used = 1'b0;
    dec_rq      = 4'd0;
    dec_rq_used = 1'b0;
    dec_rd      = 4'd0;
    dec_rd_wr   = 1'b0;
    ex_redirect = 1'b0;
    wb_valid    = 1'b0;
    wb_rd       = 4'd0;
  endtask

  task automatic dec(input logic [3:0] rs, input logic rsu, input logic [3:0] rq,
                     input logic rqu, input logic [3:0] rd, input logic rdw);
    dec_valid   = 1'b1;
    dec_rs      = rs;
    dec_rs_used = rsu;
    dec_rq      = rq;
    dec_rq_used = rqu;
    dec_rd      = rd;
    dec_rd_wr   = rdw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_in();
    rst = 1'b1;
    // controls forced low during reset even with redirect and a valid instruction
    dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1);
    ex_redirect = 1'b1;
    #1;
    chk("rst_issue", 32'(issue), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush_ex", 32'(flush_ex), 32'd0);
    chk("rst_flush_dec", 32'(flush_dec), 32'd0);
    tick();
    chk("rst_busy", 32'(busy_mask), 32'h0);
    chk("rst_infl", 32'(inflight), 32'd0);
    rst = 1'b0;
    idle_in();

    // 1: RAW stall then same-cycle writeback bypass
    dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1);
    #1;
    chk("t1_issue_w", 32'(issue), 32'd1);
    chk("t1_stall_w", 32'(stall), 32'd0);
    tick();
    chk("t1_busy", 32'(busy_mask), 32'h0008);
    chk("t1_infl", 32'(inflight), 32'd1);
    dec(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    #1;
    chk("t1_raw_stall", 32'(stall), 32'd1);
    chk("t1_raw_issue", 32'(issue), 32'd0);
    tick();
    chk("t1_busy_hold", 32'(busy_mask), 32'h0008);
    wb_valid = 1'b1;
    wb_rd    = 4'd3;
    #1;
    chk("t1_byp_issue", 32'(issue), 32'd1);
    chk("t1_byp_stall", 32'(stall), 32'd0);
    tick();
    idle_in();
    chk("t1_busy_clr", 32'(busy_mask), 32'h0);
    chk("t1_infl_clr", 32'(inflight), 32'd0);

    // 2: WAW stall; retire and re-issue to same reg keeps it busy
    dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1);
    tick();
    #1;
    chk("t2_waw_stall", 32'(stall), 32'd1);
    chk("t2_waw_issue", 32'(issue), 32'd0);
    wb_valid = 1'b1;
    wb_rd    = 4'd5;
    #1;
    chk("t2_byp_issue", 32'(issue), 32'd1);
    tick();
    chk("t2_busy", 32'(busy_mask), 32'h0020);
    chk("t2_infl", 32'(inflight), 32'd1);
    idle_in();
    wb_valid = 1'b1;
    wb_rd    = 4'd5;
    tick();
    idle_in();
    chk("t2_busy_clr", 32'(busy_mask), 32'h0);
    chk("t2_infl_clr", 32'(inflight), 32'd0);

    // 3: redirect window of two cycles, then restart of window from FLUSH
    dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    ex_redirect = 1'b1;
    #1;
    chk("t3_c0_flush_ex", 32'(flush_ex), 32'd1);
    chk("t3_c0_flush_dec", 32'(flush_dec), 32'd1);
    chk("t3_c0_issue", 32'(issue), 32'd0);
    chk("t3_c0_stall", 32'(stall), 32'd0);
    tick();
    ex_redirect = 1'b0;
    #1;
    chk("t3_c1_flush_ex", 32'(flush_ex), 32'd0);
    chk("t3_c1_flush_dec", 32'(flush_dec), 32'd1);
    chk("t3_c1_issue", 32'(issue), 32'd0);
    tick();
    chk("t3_c2_flush_dec", 32'(flush_dec), 32'd0);
    chk("t3_c2_issue", 32'(issue), 32'd1);
    ex_redirect = 1'b1;
    tick();
    #1;
    chk("t3_r1_flush_ex", 32'(flush_ex), 32'd1);
    chk("t3_r1_flush_dec", 32'(flush_dec), 32'd1);
    tick();
    ex_redirect = 1'b0;
    #1;
    chk("t3_r2_flush_dec", 32'(flush_dec), 32'd1);
    chk("t3_r2_issue", 32'(issue), 32'd0);
    tick();
    chk("t3_r3_flush_dec", 32'(flush_dec), 32'd0);
    chk("t3_r3_issue", 32'(issue), 32'd1);
    idle_in();

    // 4: in-flight cap
    for (int i = 1; i <= 4; i++) begin
      dec(4'd0, 1'b0, 4'd0, 1'b0, 4'(i), 1'b1);
      tick();
    end
    chk("t4_infl_max", 32'(inflight), 32'd4);
    chk("t4_busy_max", 32'(busy_mask), 32'h001E);
    dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1);
    #1;
    chk("t4_cap_stall", 32'(stall), 32'd1);
    chk("t4_cap_issue", 32'(issue), 32'd0);
    wb_valid = 1'b1;
    wb_rd    = 4'd2;
    #1;
    chk("t4_wb_issue", 32'(issue), 32'd1);
    chk("t4_wb_stall", 32'(stall), 32'd0);
    tick();
    chk("t4_infl_keep", 32'(inflight), 32'd4);
    chk("t4_busy_swap", 32'(busy_mask), 32'h021A);
    idle_in();
    dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    #1;
    chk("t4_nowr_issue", 32'(issue), 32'd1);
    idle_in();
    wb_valid = 1'b1;
    wb_rd    = 4'd1;
    tick();
    wb_rd = 4'd9;
    tick();
    idle_in();
    chk("t4_busy_18", 32'(busy_mask), 32'h0018);
    chk("t4_infl_2", 32'(inflight), 32'd2);

    // 5: reset in the middle of a flush window
    ex_redirect = 1'b1;
    tick();
    ex_redirect = 1'b0;
    dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    #1;
    chk("t5_in_flush", 32'(flush_dec), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_flush_dec", 32'(flush_dec), 32'd0);
    chk("t5_rst_issue", 32'(issue), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_busy", 32'(busy_mask), 32'h0);
    chk("t5_infl", 32'(inflight), 32'd0);
    chk("t5_flush_dec", 32'(flush_dec), 32'd0);
    chk("t5_issue_idle", 32'(issue), 32'd1);
    idle_in();

    // 6: retire at zero in-flight is ignored; operand-used qualifiers
    wb_valid = 1'b1;
    wb_rd    = 4'd7;
    tick();
    idle_in();
    chk("t6_infl_nowrap", 32'(inflight), 32'd0);
`ifdef HAZARD_ERR_EN
    chk("t6_err_set", 32'(err), 32'd1);
`endif
    dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1);
    tick();
    chk("t6_busy6", 32'(busy_mask), 32'h0040);
    dec(4'd6, 1'b0, 4'd6, 1'b1, 4'd0, 1'b0);
    #1;
    chk("t6_rq_stall", 32'(stall), 32'd1);
    dec(4'd6, 1'b0, 4'd2, 1'b1, 4'd0, 1'b0);
    #1;
    chk("t6_rs_imm_issue", 32'(issue), 32'd1);
    tick();
`ifdef HAZARD_ERR_EN
    chk("t6_err_sticky", 32'(err), 32'd1);
`endif
    idle_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
